reg_bank_writer: RTL and testbench
==================================

Name: reg_bank_writer

Overview:
- Write side of the CPU register file: holds sixteen 16-bit general registers and drives them out in parallel as r0..r15.
- Those outputs feed the register read mux directly.
- Accepts single-register writes over a valid/ready handshake with byte enables.
- Provides a sequenced clear-all operation that zeroes the bank one register per cycle.

Parameters:
- DATA_W, 16, register width in bits; must be 16 to match the read mux; byte-enable logic assumes DATA_W = 16.
- NUM_REGS, 16, register count; fixed at 16 (4-bit select).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- wr_valid  input  1  write request
- wr_ready  output  1  bank can accept a write this cycle
- wr_sel  input  4  destination register index
- wr_data  input  16  write data
- wr_be  input  2  byte enables; [0] = bits 7:0, [1] = bits 15:8
- wr_ack  output  1  one-cycle pulse, one cycle after an accepted write
- clr_req  input  1  request clear of all registers
- clr_busy  output  1  clear sequence in progress
- r0 .. r15  output  16 each  current register contents

Behaviour:
- Reset (async, active-high, takes effect immediately):
  - r0..r15 = 16'h0000, state = IDLE, clear index = 0.
  - wr_ack = 0, clr_busy = 0.
  - wr_ready follows its combinational definition, so it is 1 while clr_req = 0.
- States:
  - IDLE: clr_req = 1 -> CLEAR with index = first clearable register. Otherwise stay.
  - CLEAR: each cycle reg[index] <= 0 and index increments. At index 15 return to IDLE on the next edge.
- wr_ready = (state == IDLE) && !clr_req. This is combinational. clr_req has priority over a same-cycle write, and that write is not accepted.
- Accept condition: wr_valid && wr_ready at a rising clk edge.
  - On accept, reg[wr_sel] bytes with wr_be set take wr_data; other bytes keep their value.
  - The new value is visible on r<wr_sel> after that edge (1-cycle write latency).
  - wr_ack = 1 for exactly the following cycle.
- wr_be = 2'b00: write is accepted, no register changes, wr_ack still pulses.
- Back-to-back writes: one write per cycle is allowed. wr_ack stays high continuously for consecutive accepts.
- Repeated writes to the same register: the last accepted write wins.
- clr_busy = (state == CLEAR).
  - It asserts on the edge after clr_req is sampled in IDLE.
  - It stays high for one cycle per cleared register: 16 cycles normally.
  - wr_ready = 0 throughout.
- clr_req while in CLEAR is ignored; no restart or extension.
- Registers not yet reached by the clear sequence keep their values until their cycle.
- A write accepted on the edge where clr_req is sampled cannot occur, because ready is low.
- Reset mid-CLEAR: all registers are 0 immediately, state is IDLE, wr_ack is 0.
- No X propagation: all outputs come directly from registers except wr_ready.

Optional Feature:
- Macro REGBANK_R0_ZERO_EN.
- When defined:
  - r0 is hardwired to 16'h0000.
  - Writes with wr_sel = 0 are accepted and pulse wr_ack, but are discarded.
  - The clear sequence walks registers 1..15, so clr_busy is high for 15 cycles.
- When undefined:
  - r0 is an ordinary register.
  - Clear walks 0..15, so clr_busy is high for 16 cycles.

Test Plan:
- Reset release, then write sel=5, data=16'hBEEF, be=2'b11 -> r5 = 16'hBEEF one cycle later; wr_ack high for one cycle; all other registers 0.
- r5 = 16'hBEEF, then write sel=5, data=16'h1234, be=2'b01 -> r5 = 16'hBE34. Then be=2'b00 -> r5 unchanged, wr_ack pulses.
- Writes to sel 0..15 on consecutive cycles with data = 16'hA000+sel -> each rN = 16'hA000+N; wr_ack high 16 consecutive cycles.
- All registers loaded nonzero, clr_req pulse together with wr_valid (sel=3) -> the write is not accepted (wr_ready = 0). clr_busy is high for 16 cycles (15 with the macro). r3 is cleared on the 4th busy cycle, or the 3rd with the macro. All registers end at 0 (r0 too without the macro), and wr_ready returns to 1 afterwards.
- Clear started, async rst asserted on busy cycle 6 mid-clock -> all rN = 0 and clr_busy = 0 immediately. The first write after reset is accepted normally.
- With REGBANK_R0_ZERO_EN, write sel=0, data=16'hFFFF -> wr_ack pulses, r0 stays 16'h0000.

Source files
------------

// File: rtl/reg_bank_writer.sv
// Write side of the CPU register file.
// Holds sixteen 16-bit registers, accepts byte-enabled single-register writes
// over valid/ready, and provides a sequenced clear-all (one register per cycle).
// Optional build macro: REGBANK_R0_ZERO_EN -- r0 reads as zero, writes to it
// are acknowledged but dropped, and the clear sequence skips it.
module reg_bank_writer #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

`ifdef REGBANK_R0_ZERO_EN
  // r0 is hardwired, so neither writes nor the clear walk touch it.
  localparam logic [3:0] FIRST_CLR = 4'd1;
  localparam bit         R0_ZERO   = 1'b1;
`else
  localparam logic [3:0] FIRST_CLR = 4'd0;
  localparam bit         R0_ZERO   = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [0:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              wr_ack_q;
  logic              accept;
  logic              sel_writable;

  // A pending clear request blocks a same-cycle write.
  assign wr_ready     = (state_q == ST_IDLE) && !clr_req;
  assign accept       = wr_valid && wr_ready;
  assign sel_writable = !(R0_ZERO && (wr_sel == 4'd0));

  // Next state of the clear sequencer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = FIRST_CLR;
        end
      end
      ST_CLEAR: begin
        if (idx_q == 4'd15) begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Next register contents: byte-merged write or the current clear step.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values assigned earlier in the same block.
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (accept && sel_writable) begin
      if (wr_be[0]) regs_d[wr_sel][7:0]        = wr_data[7:0];
      if (wr_be[1]) regs_d[wr_sel][DATA_W-1:8] = wr_data[DATA_W-1:8];
    end
    // Writes and clear steps are mutually exclusive: ready is low in CLEAR.
    if (state_q == ST_CLEAR) begin
      regs_d[idx_q] = '0;
    end
  end

  // State, index, acknowledge and register file flops.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential blocks use non-blocking '<=' so all flops update from
    // the same pre-edge values. The register file is reset too: its contents
    // are architecturally visible and must read as zero after reset.
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      wr_ack_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ack_q <= accept;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign wr_ack   = wr_ack_q;
  assign clr_busy = (state_q == ST_CLEAR);

`ifdef REGBANK_R0_ZERO_EN
  assign r0 = '0;
`else
  assign r0 = regs_q[0];
`endif
  assign r1  = regs_q[1];
  assign r2  = regs_q[2];
  assign r3  = regs_q[3];
  assign r4  = regs_q[4];
  assign r5  = regs_q[5];
  assign r6  = regs_q[6];
  assign r7  = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];
  assign r15 = regs_q[15];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: table-driven write vectors,
// hand-written clear/reset sequences and a randomized run against a
// behavioural model (register array plus a queue of pending clear indices).
module tb_reg_bank_writer;

`ifdef REGBANK_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  localparam int FIRST = R0Z ? 1 : 0;
  localparam int NCLR  = 16 - FIRST;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        wr_ack;
  logic        clr_req;
  logic        clr_busy;
  logic [15:0] rv [16];

  always #5 clk = ~clk;

  reg_bank_writer dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .r0(rv[0]),   .r1(rv[1]),   .r2(rv[2]),   .r3(rv[3]),
    .r4(rv[4]),   .r5(rv[5]),   .r6(rv[6]),   .r7(rv[7]),
    .r8(rv[8]),   .r9(rv[9]),   .r10(rv[10]), .r11(rv[11]),
    .r12(rv[12]), .r13(rv[13]), .r14(rv[14]), .r15(rv[15])
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  // Reference model: what the bank should hold, and which registers a clear
  // still has to zero (one per cycle, front first).
  logic [15:0] m [16];
  int          clr_q [$];
  bit          exp_ack;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    clr_q.delete();
    exp_ack = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [3:0] s, input logic [15:0] d,
                            input logic [1:0] be, input bit c);
    bit          rdy;
    logic [15:0] mask;
    rdy     = (clr_q.size() == 0) && !c;
    exp_ack = v && rdy;
    if (clr_q.size() != 0) begin
      m[clr_q.pop_front()] = 16'h0000;
    end else if (c) begin
      for (int i = FIRST; i < 16; i++) clr_q.push_back(i);
    end else if (v && !(R0Z && s == 4'd0)) begin
      mask = {be[1] ? 8'hFF : 8'h00, be[0] ? 8'hFF : 8'h00};
      m[s] = (m[s] & ~mask) | (d & mask);
    end
  endtask

  task automatic check_all(input string name);
    check({name, " ack"}, {15'd0, wr_ack}, {15'd0, exp_ack});
    check({name, " busy"}, {15'd0, clr_busy}, {15'd0, clr_q.size() != 0});
    for (int i = 0; i < 16; i++) check($sformatf("%s r%0d", name, i), rv[i], m[i]);
  endtask

  // One clock cycle: drive inputs, check ready, clock, compare with model.
  task automatic cycle(input string name, input bit v, input logic [3:0] s,
                       input logic [15:0] d, input logic [1:0] be, input bit c);
    wr_valid = v; wr_sel = s; wr_data = d; wr_be = be; clr_req = c;
    #1;
    check({name, " ready"}, {15'd0, wr_ready}, {15'd0, (clr_q.size() == 0) && !c});
    model_edge(v, s, d, be, c);
    @(posedge clk);
    #1;
    check_all(name);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          n;
    int          clear_at;
    logic [15:0] prev3;

    vecs[0] = '{sel: 4'd5, data: 16'hBEEF, be: 2'b11, exp: 16'hBEEF};
    vecs[1] = '{sel: 4'd5, data: 16'h1234, be: 2'b01, exp: 16'hBE34};
    vecs[2] = '{sel: 4'd5, data: 16'h0000, be: 2'b00, exp: 16'hBE34};
    vecs[3] = '{sel: 4'd5, data: 16'h56AB, be: 2'b10, exp: 16'h5634};
    vecs[4] = '{sel: 4'd7, data: 16'hFFFF, be: 2'b01, exp: 16'h00FF};
    vecs[5] = '{sel: 4'd7, data: 16'h1200, be: 2'b10, exp: 16'h12FF};
    vecs[6] = '{sel: 4'd0, data: 16'hFFFF, be: 2'b11, exp: R0Z ? 16'h0000 : 16'hFFFF};

    // Reset state.
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 4'd0; wr_data = 16'h0; wr_be = 2'b00; clr_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {15'd0, wr_ready}, 16'd1);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single writes, each followed by an idle cycle so the
    // one-cycle acknowledge pulse is seen to drop.
    for (int i = 0; i < 7; i++) begin
      cycle($sformatf("vec%0d", i), 1'b1, vecs[i].sel, vecs[i].data, vecs[i].be, 1'b0);
      check($sformatf("vec%0d value", i), rv[vecs[i].sel], vecs[i].exp);
      check($sformatf("vec%0d ack", i), {15'd0, wr_ack}, 16'd1);
      cycle($sformatf("vec%0d idle", i), 1'b0, 4'd0, 16'h0, 2'b00, 1'b0);
      check($sformatf("vec%0d ack drop", i), {15'd0, wr_ack}, 16'd0);
    end

    // Back-to-back writes to every register.
    for (int s = 0; s < 16; s++) begin
      cycle($sformatf("b2b%0d", s), 1'b1, s[3:0], 16'hA000 + 16'(s), 2'b11, 1'b0);
      check($sformatf("b2b%0d ack", s), {15'd0, wr_ack}, 16'd1);
    end
    for (int s = 0; s < 16; s++)
      check($sformatf("b2b r%0d", s), rv[s], (R0Z && s == 0) ? 16'h0000 : 16'hA000 + 16'(s));

    // Clear request collides with a write to r3: write must be refused.
    wr_valid = 1'b1; wr_sel = 4'd3; wr_data = 16'h5555; wr_be = 2'b11; clr_req = 1'b1;
    #1;
    check("clr collide ready", {15'd0, wr_ready}, 16'd0);
    cycle("clr start", 1'b1, 4'd3, 16'h5555, 2'b11, 1'b1);
    check("clr busy first", {15'd0, clr_busy}, 16'd1);
    check("clr r3 kept", rv[3], 16'hA003);
    n = 0; clear_at = 0;
    while (clr_busy && n < 40) begin
      n++;
      prev3 = rv[3];
      // Re-request and attempt writes mid-clear: both must be ignored.
      cycle($sformatf("clr%0d", n), 1'b1, 4'd1, 16'hFFFF, 2'b11, (n >= 2 && n <= 5));
      if (prev3 != 16'h0000 && rv[3] == 16'h0000) clear_at = n;
    end
    check("clr busy cycles", 16'(n), 16'(NCLR));
    check("clr r3 cycle", 16'(clear_at), R0Z ? 16'd3 : 16'd4);
    for (int s = 0; s < 16; s++) check($sformatf("clr end r%0d", s), rv[s], 16'h0000);
    wr_valid = 1'b0; clr_req = 1'b0;
    #1;
    check("clr end ready", {15'd0, wr_ready}, 16'd1);

    // Reset in the middle of a clear.
    cycle("pre rst a", 1'b1, 4'd10, 16'h1234, 2'b11, 1'b0);
    cycle("pre rst b", 1'b1, 4'd14, 16'h8001, 2'b11, 1'b0);
    cycle("mid clr start", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1);
    for (int k = 1; k <= 5; k++) cycle($sformatf("mid clr%0d", k), 1'b0, 4'd0, 16'h0, 2'b00, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("post rst write", 1'b1, 4'd6, 16'hC0DE, 2'b11, 1'b0);
    check("post rst r6", rv[6], 16'hC0DE);
    check("post rst ack", {15'd0, wr_ack}, 16'd1);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      cycle($sformatf("rnd%0d", t), $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
